// File: rtl/memory_access.sv
// ME stage of the pipelined MIPS core: word loads/stores over a req/ack data-memory handshake.
// Optional misaligned-access trap is built when MEM_ALIGN_CHECK_EN is defined.
module memory_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] Result_EX,
    input  logic [31:0] WrDat_EX,
    input  logic [4:0]  WriteReg_EX,
    input  logic        RegWrite_EX,
    input  logic        MemToReg_EX,
    input  logic        MemWrite_EX,
    input  logic [31:0] DmemRdDat,
    input  logic        DmemAck,
    output logic        DmemReq,
    output logic        DmemWe,
    output logic [31:0] DmemAddr,
    output logic [31:0] DmemWrDat,
    output logic [31:0] ResultRdDat_ME,
    output logic [4:0]  WriteReg_ME,
    output logic        RegWrite_ME,
    output logic        Stall_ME,
    output logic        AlignFault_ME
);
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdat_q;
    logic        we_q;
    logic        load_q;
    logic        regwr_q;
    logic [4:0]  wreg_q;
    logic [31:0] res_q;
    logic [4:0]  wreg_me_q;
    logic        regwr_me_q;
    logic        fault_q;

    logic access;
    logic is_load;
    logic misalign;
    logic issue;
    logic idle;

    assign access  = MemToReg_EX | MemWrite_EX;
    assign is_load = MemToReg_EX & ~MemWrite_EX;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = access & (Result_EX[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign issue = access & ~misalign;
    assign idle  = (state_q == IDLE);

    // A request abandoned by reset must disappear at once, not at the next edge
    assign DmemReq   = ~reset & (idle ? issue : 1'b1);
    assign Stall_ME  = ~reset & (idle ? (issue & ~DmemAck) : ~DmemAck);
    assign DmemAddr  = idle ? {Result_EX[31:2], 2'b00} : addr_q;
    assign DmemWe    = idle ? MemWrite_EX : we_q;
    assign DmemWrDat = idle ? WrDat_EX : wdat_q;

    assign ResultRdDat_ME = res_q;
    assign WriteReg_ME    = wreg_me_q;
    assign RegWrite_ME    = regwr_me_q;
    assign AlignFault_ME  = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdat_q     <= '0;
            we_q       <= 1'b0;
            load_q     <= 1'b0;
            regwr_q    <= 1'b0;
            wreg_q     <= '0;
            res_q      <= '0;
            wreg_me_q  <= '0;
            regwr_me_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            // Bubble unless a branch below retires something
            res_q      <= '0;
            wreg_me_q  <= '0;
            regwr_me_q <= 1'b0;
            fault_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        addr_q  <= {Result_EX[31:2], 2'b00};
                        wdat_q  <= WrDat_EX;
                        we_q    <= MemWrite_EX;
                        load_q  <= is_load;
                        regwr_q <= RegWrite_EX & ~MemWrite_EX;
                        wreg_q  <= WriteReg_EX;
                    end
                    if (flush) begin
                        // An issued but unacked request still has to be retired on the bus
                        if (issue && !DmemAck) state_q <= DRAIN;
                    end else if (misalign) begin
                        fault_q <= 1'b1;
                    end else if (issue && !DmemAck) begin
                        state_q <= BUSY;
                    end else begin
                        res_q      <= is_load ? DmemRdDat : Result_EX;
                        wreg_me_q  <= WriteReg_EX;
                        regwr_me_q <= RegWrite_EX & ~MemWrite_EX;
                    end
                end
                BUSY: begin
                    if (DmemAck) begin
                        state_q <= IDLE;
                        if (!flush) begin
                            res_q      <= load_q ? DmemRdDat : addr_q;
                            wreg_me_q  <= wreg_q;
                            regwr_me_q <= regwr_q;
                        end
                    end else if (flush) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (DmemAck) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
